dds_cfg_writer: RTL and testbench
=================================

# dds_cfg_writer

Command-frame initiator for the DDS control register bank. It takes a byte stream from a UART receiver, parses fixed-length write frames and validates each frame's checksum and address. For every valid frame it issues a single-cycle register write (`vld`/`addr`/`data_out`), which is the write side of the bank's amplitude, frequency, resolution and phase registers. It sits between the UART RX byte interface and the DDS top-level register port.

## Interface
Parameters:
- `HEADER`, default 8'h55: frame start byte.
- `TIMEOUT_CYC`, default 50000: maximum idle cycles between bytes inside a frame (1 ms at 50 MHz).

Ports:
- `sys_clk` — in, 1 — system clock, 50 MHz.
- `sys_rst_n` — in, 1 — reset; asynchronous, active-low.
- `rx_vld` — in, 1 — one-cycle strobe; `rx_data` is valid.
- `rx_data` — in, 8 — received byte.
- `vld` — out, 1 — one-cycle register write strobe.
- `addr` — out, 32 — write address, zero-extended from the frame address byte.
- `data_out` — out, 32 — write data.
- `frame_err` — out, 1 — one-cycle pulse when a frame is dropped.
- `busy` — out, 1 — high while a frame is partially received.

Clocking and reset: one clock (`sys_clk`). Reset is asynchronous and active-low (`sys_rst_n`).

## Operation
- Frame format, 7 bytes: `HEADER`, `A`, `D3`, `D2`, `D1`, `D0`, `C`.
  - Data is sent MSB first: `data = {D3,D2,D1,D0}`.
  - `C` = `A ^ D3 ^ D2 ^ D1 ^ D0`.
- Bytes are consumed only on cycles where `rx_vld` = 1.
- FSM states and transitions:
  - IDLE: a byte equal to `HEADER` moves to ADDR. Any other byte is ignored silently.
  - ADDR: latch `A` and move to DATA. The byte counter is cleared to 0.
  - DATA: shift the byte into the 32-bit data shift register. When counter = 3, move to CHK; otherwise increment the counter.
  - CHK: compare the byte with the running XOR, check the address, then return to IDLE.
- The running XOR is cleared in IDLE and accumulates `A` and `D3..D0`.
- Legal addresses are `A` ∈ {0x00, 0x04, 0x08, 0x0C}.
- At CHK:
  - Checksum match and legal address → write.
  - Otherwise → `frame_err` pulse, no write.
- Write behaviour:
  - `addr` and `data_out` are loaded with the frame values. `vld` = 1 for exactly one cycle.
  - `addr` and `data_out` hold until the next valid write. Rejected frames never modify them.
- `HEADER`-valued bytes received mid-frame are treated as ordinary payload. There is no resync.
- Inter-byte timeout:
  - A 16-bit idle counter clears on every accepted byte and increments each cycle while not in IDLE and `rx_vld` = 0.
  - When it reaches `TIMEOUT_CYC`, the FSM returns to IDLE and `frame_err` pulses.
  - If `rx_vld` arrives in the same cycle as the counter reaches `TIMEOUT_CYC`, the byte wins and no timeout occurs.
- `busy` = 1 in ADDR, DATA and CHK, and 0 in IDLE.

## Timing
- Reset values: `vld` 0, `addr` 0, `data_out` 0, `frame_err` 0, `busy` 0. FSM in IDLE, counters 0.
- Reset asserted mid-frame:
  - The partial frame is discarded and all outputs clear immediately (asynchronously).
  - After release, the FSM starts in IDLE.
- All outputs are registered.
- Latency: `vld` (or `frame_err`) is asserted in the cycle after the clock edge that samples the `C` byte.
  - `busy` falls in that same cycle.
- `vld` and `frame_err` are never high in the same cycle.
- Timeout `frame_err` is asserted in the cycle after the counter hits `TIMEOUT_CYC`. That is `TIMEOUT_CYC`+1 cycles after the last accepted byte's edge.
- Back-to-back frames:
  - A `HEADER` byte is accepted in the same cycle that `vld` is high.
  - With `rx_vld` held high continuously, one write is produced every 7 cycles.

## Test plan
- Valid frame: send 55 04 00 00 A7 C5 66 → one `vld` pulse, `addr` = 0x00000004, `data_out` = 0x0000A7C5. `frame_err` stays 0 and `busy` is 0 afterwards.
- Bad checksum: send 55 00 00 00 01 02 00 (expected `C` is 0x03) → one `frame_err` pulse, no `vld`. `addr` and `data_out` keep their previous values.
- Illegal address: send 55 05 00 00 00 10 15 (correct checksum) → `frame_err` pulse, no `vld`.
- Timeout: send 55 08, then no bytes for `TIMEOUT_CYC`+2 cycles → `frame_err` pulse, `busy` falls. A following valid frame 55 08 00 00 00 03 0B writes `addr` 0x08, `data_out` 0x00000003.
- Noise and back-to-back: send 00 AA 55 0C 00 00 04 00 08 55 00 00 00 01 00 01 with `rx_vld` high every cycle → noise ignored. Two `vld` pulses, 7 cycles apart:
  - first: `addr` 0x0C, `data_out` 0x00000400;
  - second: `addr` 0x00, `data_out` 0x00000100.
- Reset mid-frame: assert `sys_rst_n` = 0 after `D1` of a frame → all outputs 0 without waiting for a clock edge. After release, a full valid frame writes correctly.

Source files
------------

// File: rtl/dds_cfg_writer.sv
// Frame parser that turns UART command frames into DDS register writes.
// Frame: HEADER, A, D3..D0, C with C = A ^ D3 ^ D2 ^ D1 ^ D0.
module dds_cfg_writer #(
    parameter logic [7:0] HEADER      = 8'h55,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        rx_vld,
    input  logic [7:0]  rx_data,
    output logic        vld,
    output logic [31:0] addr,
    output logic [31:0] data_out,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        CHK
    } state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

    state_t      state;
    logic [7:0]  a_lat;
    logic [31:0] shreg;
    logic [7:0]  xsum;
    logic [1:0]  cnt;
    logic [15:0] idle_cnt;

    logic timeout;
    logic addr_ok;

    // A byte arriving on the limit cycle takes priority over the timeout.
    assign timeout = (state != IDLE) && !rx_vld && (idle_cnt == TO_LIM);
    assign addr_ok = (a_lat[7:4] == 4'h0) && (a_lat[1:0] == 2'b00);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            a_lat     <= '0;
            shreg     <= '0;
            xsum      <= '0;
            cnt       <= '0;
            idle_cnt  <= '0;
            vld       <= 1'b0;
            addr      <= '0;
            data_out  <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            vld       <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE || rx_vld || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 16'd1;

            if (timeout) begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        xsum <= '0;
                        if (rx_vld && rx_data == HEADER) begin
                            state <= ADDR;
                            busy  <= 1'b1;
                        end
                    end
                    ADDR: begin
                        if (rx_vld) begin
                            a_lat <= rx_data;
                            xsum  <= xsum ^ rx_data;
                            cnt   <= '0;
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (rx_vld) begin
                            shreg <= {shreg[23:0], rx_data};
                            xsum  <= xsum ^ rx_data;
                            if (cnt == 2'd3)
                                state <= CHK;
                            else
                                cnt <= cnt + 2'd1;
                        end
                    end
                    CHK: begin
                        if (rx_vld) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (rx_data == xsum && addr_ok) begin
                                vld      <= 1'b1;
                                addr     <= {24'h0, a_lat};
                                data_out <= shreg;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_cfg_writer.sv
// Directed bench for dds_cfg_writer frame parsing and register writes.
// Byte streams are pushed into a queue and driven back-to-back.
module tb_dds_cfg_writer;

    localparam int T = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        vld;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic        frame_err;
    logic        busy;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int last_err_cyc = 0;
    int acc_cyc = 0;
    logic [31:0] va_q[$];
    logic [31:0] vd_q[$];
    int          vc_q[$];
    logic [7:0]  tx_q[$];

    dds_cfg_writer #(.HEADER(8'h55), .TIMEOUT_CYC(T)) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .rx_vld(rx_vld),
        .rx_data(rx_data),
        .vld(vld),
        .addr(addr),
        .data_out(data_out),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (vld) begin
            vld_cnt++;
            va_q.push_back(addr);
            vd_q.push_back(data_out);
            vc_q.push_back(cyc);
        end
        if (frame_err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (vld && frame_err) both_cnt++;
    end

    task automatic flush();
        while (tx_q.size() > 0) begin
            @(negedge sys_clk);
            rx_vld  = 1'b1;
            rx_data = tx_q.pop_front();
        end
        @(negedge sys_clk);
        acc_cyc = cyc;
        rx_vld  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        idle(3);
        total += 5;
        if (vld !== 1'b0) begin
            bad++; $display("FAIL rst_vld got=%b exp=0", vld);
        end
        if (addr !== 32'h0) begin
            bad++; $display("FAIL rst_addr got=%h exp=0", addr);
        end
        if (data_out !== 32'h0) begin
            bad++; $display("FAIL rst_data got=%h exp=0", data_out);
        end
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL rst_err got=%b exp=0", frame_err);
        end
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy got=%b exp=0", busy);
        end
        sys_rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_valid();
        int v0, e0;
        v0 = vld_cnt; e0 = err_cnt;
        tx_q = '{8'h55, 8'h04, 8'h00, 8'h00, 8'hA7, 8'hC5, 8'h66};
        flush();
        total += 2;
        if (vld !== 1'b1) begin
            bad++; $display("FAIL valid_latency vld=%b exp=1", vld);
        end
        if (busy !== 1'b0) begin
            bad++; $display("FAIL valid_busy got=%b exp=0", busy);
        end
        idle(3);
        total += 4;
        if (vld_cnt - v0 !== 1) begin
            bad++; $display("FAIL valid_vcnt got=%0d exp=1", vld_cnt - v0);
        end
        if (err_cnt - e0 !== 0) begin
            bad++; $display("FAIL valid_err got=%0d exp=0", err_cnt - e0);
        end
        if (addr !== 32'h4) begin
            bad++; $display("FAIL valid_addr got=%h exp=4", addr);
        end
        if (data_out !== 32'h0000A7C5) begin
            bad++; $display("FAIL valid_data got=%h exp=a7c5", data_out);
        end
    endtask

    task automatic test_bad_chk();
        int v0, e0;
        v0 = vld_cnt; e0 = err_cnt;
        tx_q = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00};
        flush();
        idle(3);
        total += 4;
        if (err_cnt - e0 !== 1) begin
            bad++; $display("FAIL chk_err got=%0d exp=1", err_cnt - e0);
        end
        if (vld_cnt - v0 !== 0) begin
            bad++; $display("FAIL chk_vld got=%0d exp=0", vld_cnt - v0);
        end
        if (addr !== 32'h4) begin
            bad++; $display("FAIL chk_addr got=%h exp=4", addr);
        end
        if (data_out !== 32'h0000A7C5) begin
            bad++; $display("FAIL chk_data got=%h exp=a7c5", data_out);
        end
    endtask

    task automatic test_bad_addr();
        int v0, e0;
        v0 = vld_cnt; e0 = err_cnt;
        tx_q = '{8'h55, 8'h05, 8'h00, 8'h00, 8'h00, 8'h10, 8'h15};
        flush();
        idle(3);
        total += 3;
        if (err_cnt - e0 !== 1) begin
            bad++; $display("FAIL badaddr_err got=%0d exp=1", err_cnt - e0);
        end
        if (vld_cnt - v0 !== 0) begin
            bad++; $display("FAIL badaddr_vld got=%0d exp=0", vld_cnt - v0);
        end
        if (addr !== 32'h4) begin
            bad++; $display("FAIL badaddr_addr got=%h exp=4", addr);
        end
    endtask

    task automatic test_timeout();
        int v0, e0;
        v0 = vld_cnt; e0 = err_cnt;
        tx_q = '{8'h55, 8'h08};
        flush();
        total += 1;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL to_busy_hi got=%b exp=1", busy);
        end
        idle(T + 3);
        total += 4;
        if (err_cnt - e0 !== 1) begin
            bad++; $display("FAIL to_err got=%0d exp=1", err_cnt - e0);
        end
        if (last_err_cyc !== acc_cyc + T + 1) begin
            bad++;
            $display("FAIL to_time got=%0d exp=%0d", last_err_cyc, acc_cyc + T + 1);
        end
        if (busy !== 1'b0) begin
            bad++; $display("FAIL to_busy_lo got=%b exp=0", busy);
        end
        if (vld_cnt - v0 !== 0) begin
            bad++; $display("FAIL to_vld got=%0d exp=0", vld_cnt - v0);
        end
        tx_q = '{8'h55, 8'h08, 8'h00, 8'h00, 8'h00, 8'h03, 8'h0B};
        flush();
        idle(2);
        total += 3;
        if (vld_cnt - v0 !== 1) begin
            bad++; $display("FAIL to_next_vld got=%0d exp=1", vld_cnt - v0);
        end
        if (addr !== 32'h8) begin
            bad++; $display("FAIL to_next_addr got=%h exp=8", addr);
        end
        if (data_out !== 32'h3) begin
            bad++; $display("FAIL to_next_data got=%h exp=3", data_out);
        end
    endtask

    task automatic test_back_to_back();
        int v0, e0, n0;
        v0 = vld_cnt; e0 = err_cnt; n0 = va_q.size();
        tx_q = '{8'h00, 8'hAA, 8'h55, 8'h0C, 8'h00, 8'h00, 8'h04, 8'h00,
                 8'h08, 8'h55, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
        flush();
        idle(3);
        total += 2;
        if (vld_cnt - v0 !== 2) begin
            bad++; $display("FAIL b2b_vcnt got=%0d exp=2", vld_cnt - v0);
        end
        if (err_cnt - e0 !== 0) begin
            bad++; $display("FAIL b2b_err got=%0d exp=0", err_cnt - e0);
        end
        if (va_q.size() >= n0 + 2) begin
            total += 5;
            if (va_q[n0] !== 32'h0C) begin
                bad++; $display("FAIL b2b_a1 got=%h exp=c", va_q[n0]);
            end
            if (vd_q[n0] !== 32'h400) begin
                bad++; $display("FAIL b2b_d1 got=%h exp=400", vd_q[n0]);
            end
            if (va_q[n0+1] !== 32'h0) begin
                bad++; $display("FAIL b2b_a2 got=%h exp=0", va_q[n0+1]);
            end
            if (vd_q[n0+1] !== 32'h100) begin
                bad++; $display("FAIL b2b_d2 got=%h exp=100", vd_q[n0+1]);
            end
            if (vc_q[n0+1] - vc_q[n0] !== 7) begin
                bad++;
                $display("FAIL b2b_gap got=%0d exp=7", vc_q[n0+1] - vc_q[n0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        tx_q = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h01};
        flush();
        total += 1;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL mid_busy got=%b exp=1", busy);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        total += 4;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy);
        end
        if (data_out !== 32'h0) begin
            bad++; $display("FAIL mid_rst_data got=%h exp=0", data_out);
        end
        if (addr !== 32'h0) begin
            bad++; $display("FAIL mid_rst_addr got=%h exp=0", addr);
        end
        if (vld !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL mid_rst_strb got=%b%b exp=00", vld, frame_err);
        end
        idle(2);
        sys_rst_n = 1'b1;
        idle(1);
        v0 = vld_cnt;
        tx_q = '{8'h55, 8'h0C, 8'h12, 8'h34, 8'h56, 8'h78, 8'h04};
        flush();
        idle(2);
        total += 3;
        if (vld_cnt - v0 !== 1) begin
            bad++; $display("FAIL mid_next_vld got=%0d exp=1", vld_cnt - v0);
        end
        if (addr !== 32'h0C) begin
            bad++; $display("FAIL mid_next_addr got=%h exp=c", addr);
        end
        if (data_out !== 32'h12345678) begin
            bad++; $display("FAIL mid_next_data got=%h exp=12345678", data_out);
        end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_bad_chk();
        test_bad_addr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        total += 1;
        if (both_cnt !== 0) begin
            bad++; $display("FAIL vld_err_overlap got=%0d exp=0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
